interesting_pixel_detector: RTL and testbench

Front end of the marker tracker: scans the raw YCrCb pixel stream, classifies each pixel into one of four marker colors against programmable chroma boxes, suppresses isolated noise with a horizontal run-length filter, and emits the interesting-pixel stream (`color`, `interesting_x`, `interesting_y`, `interesting_flag`) plus the end-of-frame `frame_flag` consumed by `object_recognition`.

---
 rtl/interesting_pixel_detector_if.sv | 29 ++
 rtl/interesting_pixel_detector.sv | 196 +++++++++++++++++++
 tb/tb_interesting_pixel_detector.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interesting_pixel_detector_if.sv
// Pixel stream, threshold programming and interesting-pixel result bundle
// for the marker tracker front end.
interface interesting_pixel_detector_if;
    logic       pixel_valid;
    logic       pixel_sof;
    logic [7:0] pixel_y;
    logic [7:0] pixel_cr;
    logic [7:0] pixel_cb;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [1:0] color;
    logic [9:0] interesting_x;
    logic [8:0] interesting_y;
    logic       interesting_flag;
    logic       frame_flag;

    modport master (
        output pixel_valid, pixel_sof, pixel_y, pixel_cr, pixel_cb,
        output cfg_we, cfg_addr, cfg_data,
        input  color, interesting_x, interesting_y, interesting_flag, frame_flag
    );

    modport slave (
        input  pixel_valid, pixel_sof, pixel_y, pixel_cr, pixel_cb,
        input  cfg_we, cfg_addr, cfg_data,
        output color, interesting_x, interesting_y, interesting_flag, frame_flag
    );
endinterface

// File: rtl/interesting_pixel_detector.sv
// Classifies YCrCb pixels against four programmable chroma boxes, filters
// short horizontal runs and reports surviving pixels with their coordinates.
module interesting_pixel_detector #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int RUN_LEN = 3,
    parameter int Y_MIN   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    interesting_pixel_detector_if.slave   bus
);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, BLANK} state_t;

    localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST  = 9'(HEIGHT - 1);
    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);
    localparam logic [7:0] Y_FLOOR = 8'(Y_MIN);

    state_t     state_reg, state_next;
    logic [9:0] x_reg, x_next, cur_x;
    logic [8:0] y_reg, y_next, cur_y;
    logic       accept, cur_last;

    logic [7:0] thr_reg [16];
    logic [3:0] hit;
    logic [1:0] cls;

    logic       s1_valid_reg, s1_match_reg, s1_sof_reg, s1_last_reg;
    logic [1:0] s1_color_reg;
    logic [9:0] s1_x_reg;
    logic [8:0] s1_y_reg;

    logic [3:0] run_cnt_reg, run_cnt_next;
    logic [1:0] run_color_reg, run_color_next;
    logic       report_next;

    logic       s2_report_reg, s2_last_reg;
    logic [1:0] s2_color_reg;
    logic [9:0] s2_x_reg;
    logic [8:0] s2_y_reg;

    logic       out_flag_reg, out_last_reg, frame_flag_reg;
    logic [1:0] out_color_reg;
    logic [9:0] out_x_reg;
    logic [8:0] out_y_reg;

    // Frame tracking: SOF always restarts at (0,0), otherwise only ACTIVE accepts pixels.
    always_comb begin
        accept     = bus.pixel_valid & (bus.pixel_sof | (state_reg == ACTIVE));
        cur_x      = bus.pixel_sof ? 10'd0 : x_reg;
        cur_y      = bus.pixel_sof ? 9'd0  : y_reg;
        cur_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        if (accept) begin
            state_next = cur_last ? BLANK : ACTIVE;
            if (cur_x == X_LAST) begin
                x_next = 10'd0;
                y_next = (cur_y == Y_LAST) ? 9'd0 : cur_y + 9'd1;
            end else begin
                x_next = cur_x + 10'd1;
                y_next = cur_y;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= WAIT_SOF;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    // Even fields are minima, odd fields maxima; reset leaves every box empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                thr_reg[i] <= (i % 2 == 0) ? 8'hFF : 8'h00;
        end else if (bus.cfg_we) begin
            thr_reg[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cls
            assign hit[gi] = (bus.pixel_y >= Y_FLOOR)
                          && (bus.pixel_cr >= thr_reg[4*gi])   && (bus.pixel_cr <= thr_reg[4*gi+1])
                          && (bus.pixel_cb >= thr_reg[4*gi+2]) && (bus.pixel_cb <= thr_reg[4*gi+3]);
        end
    endgenerate

    always_comb begin
        cls = 2'd3;
        if (hit[0])      cls = 2'd0;
        else if (hit[1]) cls = 2'd1;
        else if (hit[2]) cls = 2'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_match_reg <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_color_reg <= '0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_match_reg <= |hit;
            s1_sof_reg   <= bus.pixel_sof;
            s1_last_reg  <= cur_last;
            s1_color_reg <= cls;
            s1_x_reg     <= cur_x;
            s1_y_reg     <= cur_y;
        end
    end

    // Run filter: a stale color after a miss is harmless because the count is already 0.
    always_comb begin
        run_cnt_next   = run_cnt_reg;
        run_color_next = run_color_reg;
        if (s1_valid_reg) begin
            run_color_next = s1_color_reg;
            if (!s1_match_reg)
                run_cnt_next = 4'd0;
            else if ((s1_x_reg == 10'd0) || (s1_color_reg != run_color_reg))
                run_cnt_next = 4'd1;
            else if (run_cnt_reg < RUN_MAX)
                run_cnt_next = run_cnt_reg + 4'd1;
        end
        report_next = s1_valid_reg && s1_match_reg && (run_cnt_next >= RUN_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_reg   <= '0;
            run_color_reg <= '0;
            s2_report_reg <= 1'b0;
            s2_last_reg   <= 1'b0;
            s2_color_reg  <= '0;
            s2_x_reg      <= '0;
            s2_y_reg      <= '0;
        end else begin
            run_cnt_reg   <= run_cnt_next;
            run_color_reg <= run_color_next;
            s2_report_reg <= report_next;
            s2_last_reg   <= s1_valid_reg & s1_last_reg;
            s2_color_reg  <= s1_color_reg;
            s2_x_reg      <= s1_x_reg;
            s2_y_reg      <= s1_y_reg;
        end
    end

    // A new SOF cancels an end-of-frame marker still in flight so frame_flag cannot re-rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_flag_reg   <= 1'b0;
            out_last_reg   <= 1'b0;
            frame_flag_reg <= 1'b0;
            out_color_reg  <= '0;
            out_x_reg      <= '0;
            out_y_reg      <= '0;
        end else begin
            out_flag_reg <= s2_report_reg;
            if (s2_report_reg) begin
                out_color_reg <= s2_color_reg;
                out_x_reg     <= s2_x_reg;
                out_y_reg     <= s2_y_reg;
            end
            if (s1_valid_reg && s1_sof_reg) begin
                out_last_reg   <= 1'b0;
                frame_flag_reg <= 1'b0;
            end else begin
                out_last_reg <= s2_last_reg;
                if (out_last_reg)
                    frame_flag_reg <= 1'b1;
            end
        end
    end

    assign bus.color            = out_color_reg;
    assign bus.interesting_x    = out_x_reg;
    assign bus.interesting_y    = out_y_reg;
    assign bus.interesting_flag = out_flag_reg;
    assign bus.frame_flag       = frame_flag_reg;

endmodule

// File: tb/tb_interesting_pixel_detector.sv
// Directed bench for interesting_pixel_detector using a short (16-line) frame.
module tb_interesting_pixel_detector;

    typedef struct {
        int cyc;
        int c;
        int x;
        int y;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_px_cyc = 0;
    int   mark_cyc = 0;
    int   ff_rises = 0;
    int   ff_rise_cyc = -1;
    logic ff_prev = 1'b0;
    ev_t  q[$];

    interesting_pixel_detector_if bus();

    interesting_pixel_detector #(
        .WIDTH(640), .HEIGHT(16), .RUN_LEN(3), .Y_MIN(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.interesting_flag === 1'b1) begin
            ev_t e;
            e.cyc = cyc;
            e.c   = int'(bus.color);
            e.x   = int'(bus.interesting_x);
            e.y   = int'(bus.interesting_y);
            q.push_back(e);
            $display("flag: color=%0d x=%0d y=%0d at edge %0d", e.c, e.x, e.y, e.cyc);
        end
        if (bus.frame_flag === 1'b1 && ff_prev === 1'b0) begin
            ff_rises++;
            ff_rise_cyc = cyc;
        end
        ff_prev = bus.frame_flag;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic px(input logic sof, input logic [7:0] y, input logic [7:0] cr, input logic [7:0] cb);
        bus.pixel_valid = 1'b1;
        bus.pixel_sof   = sof;
        bus.pixel_y     = y;
        bus.pixel_cr    = cr;
        bus.pixel_cb    = cb;
        tick();
        last_px_cyc     = cyc;
        bus.pixel_valid = 1'b0;
        bus.pixel_sof   = 1'b0;
    endtask

    task automatic gray(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 8'd128, 8'd128, 8'd128);
    endtask

    task automatic red(input logic sof);
        px(sof, 8'd100, 8'd210, 8'd50);
    endtask

    task automatic cfg(input logic [3:0] addr, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
        $display("cfg: addr=%0d data=%0d", addr, data);
    endtask

    task automatic cfg_color2();
        cfg(4'd8, 8'd200);
        cfg(4'd9, 8'd220);
        cfg(4'd10, 8'd40);
        cfg(4'd11, 8'd60);
    endtask

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_sof   = 1'b0;
        bus.pixel_y     = '0;
        bus.pixel_cr    = '0;
        bus.pixel_cb    = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset state
        chk("rst_flag",  int'(bus.interesting_flag), 0);
        chk("rst_frame", int'(bus.frame_flag), 0);
        chk("rst_x",     int'(bus.interesting_x), 0);
        chk("rst_y",     int'(bus.interesting_y), 0);
        chk("rst_color", int'(bus.color), 0);

        // Full gray frame with default thresholds
        px(1'b1, 8'd128, 8'd128, 8'd128);
        gray(640 * 8);
        chk("midframe_frame_flag", int'(bus.frame_flag), 0);
        gray(640 * 8 - 1);
        mark_cyc = last_px_cyc;
        idle(5);
        chk("gray_no_flags", q.size(), 0);
        chk("ff_rises", ff_rises, 1);
        chk("ff_rise_edge", ff_rise_cyc, mark_cyc + 3);
        chk("ff_high_blank", int'(bus.frame_flag), 1);
        gray(2);
        chk("ff_ignores_nonsof", int'(bus.frame_flag), 1);
        px(1'b1, 8'd128, 8'd128, 8'd128);
        chk("ff_held_at_sof", int'(bus.frame_flag), 1);
        tick();
        chk("ff_falls_after_sof", int'(bus.frame_flag), 0);

        // Color 2 run on line 10
        cfg_color2();
        px(1'b1, 8'd128, 8'd128, 8'd128);
        gray(10 * 640 + 100 - 1);
        red(1'b0);
        red(1'b0);
        red(1'b0);
        mark_cyc = last_px_cyc;
        red(1'b0);
        red(1'b0);
        gray(3);
        idle(4);
        chk("run_count", q.size(), 3);
        if (q.size() == 3) begin
            chk("run0_x", q[0].x, 102);
            chk("run0_y", q[0].y, 10);
            chk("run0_color", q[0].c, 2);
            chk("run0_latency", q[0].cyc, mark_cyc + 2);
            chk("run1_x", q[1].x, 103);
            chk("run1_latency", q[1].cyc, mark_cyc + 3);
            chk("run2_x", q[2].x, 104);
            chk("run2_color", q[2].c, 2);
        end
        chk("hold_x", int'(bus.interesting_x), 104);
        chk("hold_flag", int'(bus.interesting_flag), 0);
        q.delete();

        // Run across a line wrap
        px(1'b1, 8'd128, 8'd128, 8'd128);
        gray(5 * 640 + 637 - 1);
        for (int i = 0; i < 5; i++) red(1'b0);
        gray(2);
        idle(4);
        chk("wrap_count", q.size(), 1);
        if (q.size() == 1) begin
            chk("wrap_x", q[0].x, 639);
            chk("wrap_y", q[0].y, 5);
        end
        q.delete();

        // Overlapping boxes and luma floor
        cfg(4'd0, 8'd160);
        cfg(4'd1, 8'd180);
        cfg(4'd2, 8'd160);
        cfg(4'd3, 8'd180);
        cfg(4'd4, 8'd170);
        cfg(4'd5, 8'd190);
        cfg(4'd6, 8'd170);
        cfg(4'd7, 8'd190);
        px(1'b1, 8'd128, 8'd128, 8'd128);
        for (int i = 1; i <= 5; i++) px(1'b0, 8'd100, 8'd175, 8'd175);
        px(1'b0, 8'd31, 8'd175, 8'd175);
        for (int i = 7; i <= 9; i++) px(1'b0, 8'd32, 8'd175, 8'd175);
        gray(2);
        idle(4);
        chk("overlap_count", q.size(), 4);
        if (q.size() == 4) begin
            chk("overlap0_x", q[0].x, 3);
            chk("overlap0_color", q[0].c, 0);
            chk("overlap2_x", q[2].x, 5);
            chk("overlap3_x", q[3].x, 9);
            chk("overlap3_color", q[3].c, 0);
        end
        q.delete();

        // Mid-line threshold rewrite, then short frame
        px(1'b1, 8'd128, 8'd128, 8'd128);
        for (int i = 1; i <= 3; i++) px(1'b0, 8'd100, 8'd170, 8'd165);
        cfg(4'd1, 8'd169);
        px(1'b0, 8'd100, 8'd170, 8'd165);
        px(1'b0, 8'd100, 8'd169, 8'd165);
        gray(2);
        idle(4);
        chk("rewrite_count", q.size(), 1);
        if (q.size() == 1) begin
            chk("rewrite_x", q[0].x, 3);
            chk("rewrite_color", q[0].c, 0);
        end
        q.delete();
        gray(8 * 640 + 298 - 8);
        red(1'b0);
        red(1'b0);
        red(1'b1);
        red(1'b0);
        red(1'b0);
        gray(1);
        idle(4);
        chk("short_count", q.size(), 1);
        if (q.size() == 1) begin
            chk("short_x", q[0].x, 2);
            chk("short_y", q[0].y, 0);
            chk("short_color", q[0].c, 2);
        end
        chk("short_no_ff", ff_rises, 1);
        q.delete();

        // Reset right after a qualifying pixel
        px(1'b1, 8'd128, 8'd128, 8'd128);
        red(1'b0);
        red(1'b0);
        red(1'b0);
        reset = 1'b1;
        idle(2);
        chk("rst2_flag", int'(bus.interesting_flag), 0);
        chk("rst2_x", int'(bus.interesting_x), 0);
        chk("rst2_y", int'(bus.interesting_y), 0);
        chk("rst2_color", int'(bus.color), 0);
        reset = 1'b0;
        idle(3);
        chk("rst2_no_inflight", q.size(), 0);
        cfg_color2();
        for (int i = 0; i < 4; i++) red(1'b0);
        idle(5);
        chk("rst2_nonsof_ignored", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
